// File: rtl/serializer_tx_if.sv
// rtl/serializer_tx_if.sv - word handshake and serial output bundle for serializer_tx
interface serializer_tx_if #(
   parameter int WIDTH = 4
);
   logic             valid_i;
   logic [WIDTH-1:0] word_i;
   logic             msb_first_i;
   logic             ready_o;
   logic             serial_o;
   logic             bit_valid_o;
   logic             frame_o;
   logic             done_o;

   modport master (
      output valid_i, word_i, msb_first_i,
      input  ready_o, serial_o, bit_valid_o, frame_o, done_o
   );

   modport slave (
      input  valid_i, word_i, msb_first_i,
      output ready_o, serial_o, bit_valid_o, frame_o, done_o
   );
endinterface

// File: rtl/serializer_tx.sv
// rtl/serializer_tx.sv - parallel-in serial-out transmitter, one bit per DIV clocks
module serializer_tx #(
   parameter int WIDTH = 4,
   parameter int DIV   = 1
) (
   input logic            clk,
   input logic            rst,
   serializer_tx_if.slave bus
);
   localparam int BW = $clog2(WIDTH);
   localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
   localparam logic [DW-1:0] LAST_DIV = DW'(DIV - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state, state_next;
   logic [WIDTH-1:0] shreg, shreg_next;
   logic             msb, msb_next;
   logic [BW-1:0]    bit_cnt, bit_cnt_next;
   logic [DW-1:0]    div_cnt, div_cnt_next;
   logic             serial, serial_next;
   logic             period_end, frame_end, ready, transfer;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         shreg   <= '0;
         msb     <= 1'b0;
         bit_cnt <= '0;
         div_cnt <= '0;
         serial  <= 1'b0;
      end else begin
         state   <= state_next;
         shreg   <= shreg_next;
         msb     <= msb_next;
         bit_cnt <= bit_cnt_next;
         div_cnt <= div_cnt_next;
         serial  <= serial_next;
      end
   end

   always_comb begin
      state_next   = state;
      shreg_next   = shreg;
      msb_next     = msb;
      bit_cnt_next = bit_cnt;
      div_cnt_next = div_cnt;
      serial_next  = serial;

      period_end = (state == SHIFT) && (div_cnt == LAST_DIV);
      frame_end  = period_end && (bit_cnt == LAST_BIT);
      // Ready in the final cycle lets a new word follow with no idle gap.
      ready      = (state == IDLE) || frame_end;
      transfer   = bus.valid_i && ready;

      bus.ready_o     = ready;
      bus.done_o      = frame_end;
      bus.frame_o     = (state == SHIFT);
      bus.bit_valid_o = (state == SHIFT) && (div_cnt == '0);
      bus.serial_o    = serial;

      if (transfer) begin
         state_next   = SHIFT;
         shreg_next   = bus.word_i;
         msb_next     = bus.msb_first_i;
         bit_cnt_next = '0;
         div_cnt_next = '0;
         serial_next  = bus.msb_first_i ? bus.word_i[WIDTH-1] : bus.word_i[0];
      end else if (frame_end) begin
         state_next   = IDLE;
         shreg_next   = '0;
         bit_cnt_next = '0;
         div_cnt_next = '0;
         serial_next  = 1'b0;
      end else if (period_end) begin
         div_cnt_next = '0;
         bit_cnt_next = bit_cnt + BW'(1);
         // The current bit always sits at the output end; shift the next one in behind it.
         if (msb) begin
            shreg_next  = {shreg[WIDTH-2:0], 1'b0};
            serial_next = shreg[WIDTH-2];
         end else begin
            shreg_next  = {1'b0, shreg[WIDTH-1:1]};
            serial_next = shreg[1];
         end
      end else if (state == SHIFT) begin
         div_cnt_next = div_cnt + DW'(1);
      end
   end
endmodule

// File: tb/tb_serializer_tx.sv
// tb/tb_serializer_tx.sv - self-checking bench for serializer_tx at DIV=1 and DIV=3
module tb_serializer_tx;
   localparam int W = 4;

   typedef struct packed {
      logic frame;
      logic bv;
      logic ser;
      logic done;
   } rec_t;

   typedef struct packed {
      logic [3:0] word;
      logic       msb;
      logic [3:0] ser;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         valid = 1'b0;
   logic [W-1:0] word = '0;
   logic         msb = 1'b0;
   int           checks = 0;
   int           errors = 0;
   int           rst_cnt = 0;
   rec_t         mq [2][$];
   logic [4:0]   obs [2];

   always #5 clk = ~clk;
   always @(posedge rst) rst_cnt++;

   serializer_tx_if #(.WIDTH(W)) b1 ();
   serializer_tx_if #(.WIDTH(W)) b3 ();

   assign b1.valid_i     = valid;
   assign b1.word_i      = word;
   assign b1.msb_first_i = msb;
   assign b3.valid_i     = valid;
   assign b3.word_i      = word;
   assign b3.msb_first_i = msb;

   serializer_tx #(.WIDTH(W), .DIV(1)) u1 (.clk(clk), .rst(rst), .bus(b1));
   serializer_tx #(.WIDTH(W), .DIV(3)) u3 (.clk(clk), .rst(rst), .bus(b3));

   assign obs[0] = {b1.ready_o, b1.frame_o, b1.bit_valid_o, b1.serial_o, b1.done_o};
   assign obs[1] = {b3.ready_o, b3.frame_o, b3.bit_valid_o, b3.serial_o, b3.done_o};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: each accepted word becomes W*DIV expected output cycles in a queue.
   initial begin : monitor
      logic         xfer [2];
      logic         rdy [2];
      int           divs [2];
      int           seen;
      int           idx;
      rec_t         e;
      logic [W-1:0] cw;
      logic         cm;
      rdy[0] = 1'b1; rdy[1] = 1'b1;
      divs[0] = 1;   divs[1] = 3;
      seen = 0;
      forever begin
         @(posedge clk);
         cw = word;
         cm = msb;
         for (int k = 0; k < 2; k++)
            xfer[k] = valid && !rst && (rdy[k] || rst_cnt != seen);
         #1;
         for (int k = 0; k < 2; k++) begin
            if (rst || rst_cnt != seen) mq[k].delete();
            if (xfer[k]) begin
               for (int c = 0; c < W * divs[k]; c++) begin
                  idx    = c / divs[k];
                  e.frame = 1'b1;
                  e.bv    = (c % divs[k]) == 0;
                  e.ser   = cm ? cw[W-1-idx] : cw[idx];
                  e.done  = (c == W * divs[k] - 1);
                  mq[k].push_back(e);
               end
            end
            if (mq[k].size() > 0) e = mq[k].pop_front();
            else e = '0;
            rdy[k] = !e.frame || e.done;
            check(k == 0 ? "div1 outputs" : "div3 outputs", 32'(obs[k]),
                  32'({rdy[k], e.frame, e.bv, e.ser, e.done}));
         end
         seen = rst_cnt;
      end
   end

   task automatic tick;
      @(posedge clk);
      #2;
   endtask

   task automatic wait_idle;
      int n = 0;
      while (!(b1.ready_o && !b1.frame_o && b3.ready_o && !b3.frame_o) && n < 40) begin
         tick();
         n++;
      end
      check("idle wait bound", 32'(n < 40), 32'd1);
   endtask

   initial begin : stim
      vec_t        vecs [7];
      logic [3:0]  ser, bvs, dn, rx, rdys;
      logic [7:0]  s8, f8, d8;
      logic [11:0] s12, v12, d12;
      int          fr;

      vecs[0] = '{4'b1011, 1'b1, 4'b1011};
      vecs[1] = '{4'b1011, 1'b0, 4'b1101};
      vecs[2] = '{4'b1010, 1'b1, 4'b1010};
      vecs[3] = '{4'b0101, 1'b0, 4'b1010};
      vecs[4] = '{4'b0001, 1'b0, 4'b1000};
      vecs[5] = '{4'b1000, 1'b0, 4'b0001};
      vecs[6] = '{4'b1110, 1'b0, 4'b0111};

      tick();
      tick();
      check("reset outputs div1", 32'(obs[0]), 32'h10);
      check("reset outputs div3", 32'(obs[1]), 32'h10);
      rst = 1'b0;
      tick();

      for (int i = 0; i < 7; i++) begin
         wait_idle();
         valid = 1'b1; word = vecs[i].word; msb = vecs[i].msb;
         tick();
         valid = 1'b0; word = 4'($urandom); msb = 1'($urandom);
         ser = '0; bvs = '0; dn = '0; rx = '0;
         for (int j = 0; j < 4; j++) begin
            ser = {ser[2:0], b1.serial_o};
            bvs = {bvs[2:0], b1.bit_valid_o};
            dn  = {dn[2:0], b1.done_o};
            if (b1.bit_valid_o)
               rx = vecs[i].msb ? {rx[2:0], b1.serial_o} : {b1.serial_o, rx[3:1]};
            if (j < 3) tick();
         end
         check("vec serial order", 32'(ser), 32'(vecs[i].ser));
         check("vec strobes", 32'(bvs), 32'hF);
         check("vec done", 32'(dn), 32'h1);
         check("vec receiver word", 32'(rx), 32'(vecs[i].word));
      end

      wait_idle();
      valid = 1'b1; word = 4'b0110; msb = 1'b1;
      tick();
      valid = 1'b0;
      s12 = '0; v12 = '0; d12 = '0; fr = 0;
      for (int j = 0; j < 12; j++) begin
         s12 = {s12[10:0], b3.serial_o};
         v12 = {v12[10:0], b3.bit_valid_o};
         d12 = {d12[10:0], b3.done_o};
         fr += int'(b3.frame_o);
         tick();
      end
      check("div3 serial", 32'(s12), 32'b000111111000);
      check("div3 strobes", 32'(v12), 32'b100100100100);
      check("div3 done", 32'(d12), 32'b000000000001);
      check("div3 frame cycles", 32'(fr), 32'd12);
      check("div3 frame end", 32'(b3.frame_o), 32'd0);

      wait_idle();
      valid = 1'b1; word = 4'hA; msb = 1'b1;
      tick();
      word = 4'h5;
      s8 = '0; f8 = '0; d8 = '0;
      for (int j = 0; j < 8; j++) begin
         s8 = {s8[6:0], b1.serial_o};
         f8 = {f8[6:0], b1.frame_o};
         d8 = {d8[6:0], b1.done_o};
         if (j == 4) valid = 1'b0;
         tick();
      end
      check("b2b serial", 32'(s8), 32'b10100101);
      check("b2b frame", 32'(f8), 32'hFF);
      check("b2b done", 32'(d8), 32'b00010001);

      wait_idle();
      valid = 1'b1; word = 4'b1100; msb = 1'b1;
      tick();
      valid = 1'b0;
      ser = '0; rdys = '0;
      for (int j = 0; j < 4; j++) begin
         ser  = {ser[2:0], b1.serial_o};
         rdys = {rdys[2:0], b1.ready_o};
         if (j == 0) begin valid = 1'b1; word = 4'b0011; msb = 1'b0; end
         if (j == 1) begin valid = 1'b1; word = 4'hF; end
         if (j == 2) valid = 1'b0;
         tick();
      end
      check("midframe word kept", 32'(ser), 32'b1100);
      check("midframe ready", 32'(rdys), 32'b0001);
      check("midframe no extra", 32'(b1.frame_o), 32'd0);

      wait_idle();
      valid = 1'b1; word = 4'b1011; msb = 1'b1;
      tick();
      valid = 1'b0;
      tick();
      check("pre-reset in frame", 32'(b1.frame_o), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("async reset div1", 32'(obs[0]), 32'h10);
      check("async reset div3", 32'(obs[1]), 32'h10);
      #1 rst = 1'b0;
      dn = '0;
      for (int j = 0; j < 4; j++) begin
         tick();
         dn = {dn[2:0], b1.done_o};
      end
      check("no done after reset", 32'(dn), 32'd0);
      check("ready after reset", 32'(b1.ready_o), 32'd1);

      for (int i = 0; i < 400; i++) begin
         valid = ($urandom_range(0, 3) != 0);
         word  = 4'($urandom);
         msb   = 1'($urandom);
         tick();
      end
      valid = 1'b0;
      wait_idle();
      tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
